sine_cosine_nco: RTL and testbench

//  Numerically controlled oscillator: phase accumulator + quarter-wave sine ROM, full-wave sin/cos via symmetry.

---
 rtl/sine_cosine_nco_if.sv | 24 ++
 rtl/sine_cosine_nco.sv | 126 ++++++++++++
 tb/tb_sine_cosine_nco.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sine_cosine_nco_if.sv
// Control/sample bundle between an NCO and its consumer.
// The master drives phase control; the slave (the NCO) returns sin/cos samples.
interface sine_cosine_nco_if #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned OUT_WIDTH   = 16
);
    logic                        en;
    logic [PHASE_WIDTH-1:0]      freq;
    logic                        phase_load;
    logic [PHASE_WIDTH-1:0]      phase_in;
    logic signed [OUT_WIDTH-1:0] sin_out;
    logic signed [OUT_WIDTH-1:0] cos_out;
    logic                        out_valid;

    modport master (
        output en, freq, phase_load, phase_in,
        input  sin_out, cos_out, out_valid
    );

    modport slave (
        input  en, freq, phase_load, phase_in,
        output sin_out, cos_out, out_valid
    );
endinterface

// File: rtl/sine_cosine_nco.sv
// Numerically controlled oscillator: phase accumulator feeding a quarter-wave sine ROM.
// Full-wave sin/cos are rebuilt from quadrant symmetry. Three-stage pipeline, no backpressure:
// a sample taken in cycle t appears on the outputs with out_valid in cycle t+3.
module sine_cosine_nco #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned TABLE_BITS  = 10,
    parameter int unsigned OUT_WIDTH   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sine_cosine_nco_if.slave  bus
);
    localparam int unsigned N   = 2 ** TABLE_BITS;
    localparam int          A   = 2 ** (OUT_WIDTH - 1) - 1;
    localparam real         PI  = 3.14159265358979323846;

    // Quarter-wave table, sampled at bin centres so sin and cos share one ROM exactly.
    logic signed [OUT_WIDTH-1:0] r_rom [N];

    function automatic logic signed [OUT_WIDTH-1:0] rom_entry(input int k);
        real x;
        x = $sin((real'(k) + 0.5) * PI / (2.0 * real'(N))) * real'(A) + 0.5;
        return OUT_WIDTH'($rtoi($floor(x)));
    endfunction

    // Fill the ROM once at elaboration.
    initial begin
        for (int k = 0; k < int'(N); k++) begin
            r_rom[k] = rom_entry(k);
        end
    end

    logic [PHASE_WIDTH-1:0]      r_acc;
    logic [1:0]                  w_q;
    logic [TABLE_BITS-1:0]       w_idx;

    logic [1:0]                  r_q1;
    logic [TABLE_BITS-1:0]       r_idx1;
    logic [TABLE_BITS-1:0]       r_ridx1;
    logic                        r_v1;

    logic signed [OUT_WIDTH-1:0] r_a2;
    logic signed [OUT_WIDTH-1:0] r_b2;
    logic [1:0]                  r_q2;
    logic                        r_v2;

    logic signed [OUT_WIDTH-1:0] r_sin;
    logic signed [OUT_WIDTH-1:0] r_cos;
    logic                        r_valid;

    // Truncated phase: quadrant from the top two bits, table index from the next TABLE_BITS.
    assign w_q   = r_acc[PHASE_WIDTH-1 -: 2];
    assign w_idx = r_acc[PHASE_WIDTH-3 -: TABLE_BITS];

    // Accumulator update and stage 1; the sample always uses the pre-update phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_q1    <= '0;
            r_idx1  <= '0;
            r_ridx1 <= '0;
            r_v1    <= 1'b0;
        end else begin
            if (bus.phase_load) begin
                r_acc <= bus.phase_in;
            end else if (bus.en) begin
                r_acc <= r_acc + bus.freq;
            end
            r_q1    <= w_q;
            r_idx1  <= w_idx;
            r_ridx1 <= ~w_idx;  // N-1-idx
            r_v1    <= bus.en;
        end
    end

    // Stage 2 ROM reads, left without reset so they map onto block RAM.
    always_ff @(posedge i_clk) begin
        r_a2 <= r_rom[r_idx1];
        r_b2 <= r_rom[r_ridx1];
        r_q2 <= r_q1;
    end

    // Stage 2 valid flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
        end
    end

    // Stage 3: quadrant reconstruction; outputs hold while no sample is arriving.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sin   <= '0;
            r_cos   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_v2;
            if (r_v2) begin
                unique case (r_q2)
                    2'd0: begin
                        r_sin <= r_a2;
                        r_cos <= r_b2;
                    end
                    2'd1: begin
                        r_sin <= r_b2;
                        r_cos <= -r_a2;
                    end
                    2'd2: begin
                        r_sin <= -r_a2;
                        r_cos <= -r_b2;
                    end
                    2'd3: begin
                        r_sin <= -r_b2;
                        r_cos <= r_a2;
                    end
                endcase
            end
        end
    end

    assign bus.sin_out   = r_sin;
    assign bus.cos_out   = r_cos;
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_sine_cosine_nco.sv
// Self-checking bench for sine_cosine_nco: directed corner cases plus randomized traffic
// against a model that evaluates sin/cos of the truncated phase directly.
module tb_sine_cosine_nco;
    localparam int unsigned PW    = 32;
    localparam int unsigned TBITS = 10;
    localparam int unsigned OW    = 16;
    localparam int          A     = 2 ** (OW - 1) - 1;
    localparam real         PI    = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sine_cosine_nco_if #(.PHASE_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

    sine_cosine_nco #(
        .PHASE_WIDTH (PW),
        .TABLE_BITS  (TBITS),
        .OUT_WIDTH   (OW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state: accumulator, 3-deep expected pipeline, held output values.
    logic [PW-1:0] m_acc = '0;
    bit            pv [3];
    int            ps [3];
    int            pc [3];
    int            hold_s = 0;
    int            hold_c = 0;
    bit            checks_on = 1'b0;
    bit            capture   = 1'b0;
    int            cap_s [$];
    int            cap_c [$];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int round_amp(input real x);
        if (x >= 0.0) return $rtoi($floor(x * A + 0.5));
        return -$rtoi($floor(-x * A + 0.5));
    endfunction

    // Ideal sin/cos evaluated at the centre of the truncated phase bin.
    task automatic model(input logic [PW-1:0] ph, output int s, output int c);
        int  u;
        real th;
        u  = int'(ph >> (PW - TBITS - 2));
        th = (real'(u) + 0.5) * 2.0 * PI / real'(2 ** (TBITS + 2));
        s  = round_amp($sin(th));
        c  = round_amp($cos(th));
    endtask

    task automatic step(input logic rst_v, input logic en_v, input logic [PW-1:0] fr,
                        input logic ld, input logic [PW-1:0] pin);
        int s;
        int c;
        @(negedge clk);
        if (checks_on) begin
            if (pv[2]) begin
                hold_s = ps[2];
                hold_c = pc[2];
            end
            check_eq("out_valid", longint'(bus.out_valid), longint'(pv[2]));
            check_eq("sin_out", longint'(bus.sin_out), longint'(hold_s));
            check_eq("cos_out", longint'(bus.cos_out), longint'(hold_c));
            if (capture && bus.out_valid) begin
                cap_s.push_back(int'(bus.sin_out));
                cap_c.push_back(int'(bus.cos_out));
            end
        end
        for (int i = 2; i > 0; i--) begin
            pv[i] = pv[i-1];
            ps[i] = ps[i-1];
            pc[i] = pc[i-1];
        end
        rst            = rst_v;
        bus.en         = en_v;
        bus.freq       = fr;
        bus.phase_load = ld;
        bus.phase_in   = pin;
        if (rst_v) begin
            for (int i = 0; i < 3; i++) pv[i] = 1'b0;
            hold_s = 0;
            hold_c = 0;
            m_acc  = '0;
        end else begin
            pv[0] = en_v;
            if (en_v) begin
                model(m_acc, s, c);
                ps[0] = s;
                pc[0] = c;
            end
            if (ld) m_acc = pin;
            else if (en_v) m_acc = m_acc + fr;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    int exp2_s [8] = '{25, 32767, -25, -32767, 25, 32767, -25, -32767};
    int exp2_c [8] = '{32767, -25, -32767, 25, 32767, -25, -32767, 25};
    int exp3_s [2] = '{-25, 25};
    int exp3_c [2] = '{32767, 32767};

    initial begin
        logic [PW-1:0] fr;
        bit            en_r;
        bit            ld_r;
        bit            rst_r;
        int            n;

        bus.en         = 1'b0;
        bus.freq       = '0;
        bus.phase_load = 1'b0;
        bus.phase_in   = '0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            ps[i] = 0;
            pc[i] = 0;
        end

        // Reset for two cycles, then idle: outputs must stay zero and invalid.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        checks_on = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0, '0);
        idle(5);

        // Quarter-turn steps from phase zero.
        capture = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h4000_0000, 1'b0, '0);
        idle(4);
        capture = 1'b0;
        check_eq("t2_count", longint'(cap_s.size()), 8);
        n = (cap_s.size() < 8) ? cap_s.size() : 8;
        for (int i = 0; i < n; i++) begin
            check_eq("t2_sin", longint'(cap_s[i]), longint'(exp2_s[i]));
            check_eq("t2_cos", longint'(cap_c[i]), longint'(exp2_c[i]));
        end

        // Seamless wrap through the top of the phase range.
        cap_s.delete();
        cap_c.delete();
        capture = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 32'd1, 1'b0, '0);
        step(1'b0, 1'b1, 32'd1, 1'b0, '0);
        idle(4);
        capture = 1'b0;
        check_eq("t3_count", longint'(cap_s.size()), 2);
        n = (cap_s.size() < 2) ? cap_s.size() : 2;
        for (int i = 0; i < n; i++) begin
            check_eq("t3_sin", longint'(cap_s[i]), longint'(exp3_s[i]));
            check_eq("t3_cos", longint'(cap_c[i]), longint'(exp3_c[i]));
        end

        // Enable gaps must hold the accumulator and show up as valid gaps.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0010_0000, 1'b0, '0);
        step(1'b0, 1'b0, 32'h0010_0000, 1'b0, '0);
        step(1'b0, 1'b0, 32'h0010_0000, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0010_0000, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0010_0000, 1'b0, '0);
        idle(4);

        // Full sweep of every table bin in all four quadrants.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4096; i++) step(1'b0, 1'b1, 32'h0010_0000, 1'b0, '0);

        // Reset while samples are in flight: nothing stale may emerge afterwards.
        step(1'b1, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check_eq("flush_valid", longint'(bus.out_valid), 0);
        check_eq("flush_sin", longint'(bus.sin_out), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        checks_on = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0, '0);
        checks_on = 1'b1;
        idle(6);

        // Randomized traffic: frequency changes, loads (incl. with en), enable gaps, resets.
        fr = $urandom();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) fr = $urandom();
            en_r  = ($urandom_range(3) != 0);
            ld_r  = ($urandom_range(29) == 0);
            rst_r = ($urandom_range(199) == 0);
            step(rst_r, en_r, fr, ld_r, $urandom());
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
